// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction fetch controller.
//   INSTMEM_ADDR_WIDTH : instruction memory address width
//   INST_LENGTH        : instruction word width
//   ifetch_state_e     : fetch controller FSM encoding
package inst_fetch_ctrl_pkg;

   localparam int unsigned INSTMEM_ADDR_WIDTH = 8;
   localparam int unsigned INST_LENGTH        = 32;

   typedef enum logic [1:0] {
      IFETCH_ST_IDLE  = 2'd0,
      IFETCH_ST_FETCH = 2'd1,
      IFETCH_ST_DRAIN = 2'd2
   } ifetch_state_e;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry synchronous FIFO of {inst, pc} with flush.
// Entry 0 is always the head, so the head outputs come straight from registers.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   flush                : drop all entries (priority over push/pop)
//   push, push_inst/pc   : write one entry
//   pop                  : remove the head (only when head_valid)
//   head_inst/pc/valid   : current head entry
//   count                : number of occupied entries (0..2)
module ifetch_buf #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned INST_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              push,
   input  logic [INST_W-1:0] push_inst,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              pop,
   output logic [INST_W-1:0] head_inst,
   output logic [ADDR_W-1:0] head_pc,
   output logic              head_valid,
   output logic [1:0]        count
);

   logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
   logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      inst0_d = inst0_q;
      inst1_d = inst1_q;
      pc0_d   = pc0_q;
      pc1_d   = pc1_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  inst0_d = push_inst;
                  pc0_d   = push_pc;
               end else begin
                  inst1_d = push_inst;
                  pc1_d   = push_pc;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               inst0_d = inst1_q;
               pc0_d   = pc1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; new data lands behind whatever remains.
               if (count_q == 2'd1) begin
                  inst0_d = push_inst;
                  pc0_d   = push_pc;
               end else begin
                  inst0_d = inst1_q;
                  pc0_d   = pc1_q;
                  inst1_d = push_inst;
                  pc1_d   = push_pc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inst0_q <= '0;
         inst1_q <= '0;
         pc0_q   <= '0;
         pc1_q   <= '0;
         count_q <= 2'd0;
      end else begin
         inst0_q <= inst0_d;
         inst1_q <= inst1_d;
         pc0_q   <= pc0_d;
         pc1_q   <= pc1_d;
         count_q <= count_d;
      end
   end

   assign head_inst  = inst0_q;
   assign head_pc    = pc0_q;
   assign head_valid = (count_q != 2'd0);
   assign count      = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction memory
// address, absorbs its 1-cycle read latency and hands instructions to the
// decoder over valid/ready through a 2-entry buffer.
// Ports:
//   clk, rstn               : clock, asynchronous active-low reset
//   start, start_addr       : begin fetching (IDLE only); end_addr sampled too
//   jump_valid, jump_addr   : redirect with flush (FETCH/DRAIN only)
//   imem_addr, imem_q       : instruction memory address / read data
//   inst, inst_pc,
//   inst_valid, inst_ready  : decoder handshake
//   busy, done              : not idle / last instruction accepted
// Optional macro IFETCH_PERF_CNT_EN adds perf_fetched and perf_stall counters.
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = INSTMEM_ADDR_WIDTH,
   parameter int unsigned INST_W    = INST_LENGTH,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_q,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic              busy,
   output logic              done
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   ifetch_state_e     state_q, state_d;
   logic [ADDR_W-1:0] pc_q, end_q, pending_pc_q;
   logic              pending_q;
   logic [1:0]        count;
   logic [2:0]        occ;
   logic              pop, issue, start_take, jump_take;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IFETCH_ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IFETCH_ST_IDLE:  if (start) state_d = IFETCH_ST_FETCH;
         IFETCH_ST_FETCH: begin
            if (jump_valid)                   state_d = IFETCH_ST_FETCH;
            else if (issue && pc_q == end_q)  state_d = IFETCH_ST_DRAIN;
         end
         IFETCH_ST_DRAIN: begin
            if (jump_valid)  state_d = IFETCH_ST_FETCH;
            else if (done)   state_d = IFETCH_ST_IDLE;
         end
         default:            state_d = IFETCH_ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy       = (state_q != IFETCH_ST_IDLE);
      start_take = (state_q == IFETCH_ST_IDLE) && start;
      jump_take  = busy && jump_valid;
      pop        = inst_valid && inst_ready;
      // Occupancy after this cycle's pop, counting the read still in flight.
      occ        = {1'b0, count} + {2'b00, pending_q} - {2'b00, pop};
      issue      = (state_q == IFETCH_ST_FETCH) && !jump_valid && (occ < 3'(BUF_DEPTH));
      // Last instruction: nothing else buffered or in flight behind it.
      done       = (state_q == IFETCH_ST_DRAIN) && pop && !jump_valid &&
                   (inst_pc == end_q) && (count == 2'd1) && !pending_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q         <= '0;
         end_q        <= '0;
         pending_q    <= 1'b0;
         pending_pc_q <= '0;
      end else begin
         if (start_take) begin
            pc_q  <= start_addr;
            end_q <= end_addr;
         end else if (jump_take) begin
            pc_q <= jump_addr;
         end else if (issue) begin
            pc_q <= pc_q + ADDR_W'(1);
         end
         pending_q <= issue;
         if (issue) pending_pc_q <= pc_q;
      end
   end

   assign imem_addr = pc_q;

   ifetch_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_buf (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (jump_take),
      .push       (pending_q),
      .push_inst  (imem_q),
      .push_pc    (pending_pc_q),
      .pop        (pop),
      .head_inst  (inst),
      .head_pc    (inst_pc),
      .head_valid (inst_valid),
      .count      (count)
   );

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else if (start_take) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (inst_valid && !inst_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

   localparam int AW = 8;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] start_addr, end_addr, jump_addr;
   logic          jump_valid;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_q;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          inst_valid, inst_ready, busy, done;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0]   perf_fetched, perf_stall;
`endif

   logic [IW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   // Results collected by run_prog
   int acc_q[$];
   int done_pcs[$];
   int inst_bad, hold_bad, ahead_bad, stall_cnt, first_valid, post_jump_valid;
   bit timed_out, busy_after_done;

   always #5 clk = ~clk;

   always @(posedge clk) imem_q <= mem[imem_addr];

   inst_fetch_ctrl #(
      .ADDR_W    (AW),
      .INST_W    (IW),
      .BUF_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .jump_valid (jump_valid),
      .jump_addr  (jump_addr),
      .imem_addr  (imem_addr),
      .imem_q     (imem_q),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .busy       (busy),
      .done       (done)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   // Runs one program and records what the decoder side saw. mode 0: ready
   // held high; mode 1: ready pattern 1,0,0,1. A jump to jump_tgt is raised
   // in the cycle that pc jump_pc is accepted (jump_pc < 0: no jump).
   task automatic run_prog(input int sa, input int ea, input int mode,
                           input int jump_pc, input int jump_tgt);
      bit            held = 0, jumped = 0, done_prev = 0;
      logic [IW-1:0] h_inst = '0;
      logic [AW-1:0] h_pc = '0;
      logic [AW-1:0] diff;
      int            jump_cyc = -10;
      acc_q.delete();
      done_pcs.delete();
      inst_bad = 0; hold_bad = 0; ahead_bad = 0; stall_cnt = 0;
      first_valid = -1; post_jump_valid = -1;
      timed_out = 1; busy_after_done = 1;
      @(negedge clk);
      start = 1; start_addr = AW'(sa); end_addr = AW'(ea);
      jump_valid = 0; inst_ready = 1;
      @(negedge clk);
      start = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (cyc > 0) @(negedge clk);
         jump_valid = 0;
         inst_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
         #1;
         if (done_prev) begin
            busy_after_done = busy;
            timed_out = 0;
            break;
         end
         if (held && (!inst_valid || inst !== h_inst || inst_pc !== h_pc)) hold_bad++;
         held = inst_valid && !inst_ready;
         h_inst = inst; h_pc = inst_pc;
         if (held) stall_cnt++;
         if (inst_valid && first_valid < 0) first_valid = cyc;
         if (cyc == jump_cyc + 1) post_jump_valid = int'(inst_valid);
         if (inst_valid) begin
            diff = imem_addr - inst_pc;
            if (diff > 2) ahead_bad++;
         end
         if (done) done_pcs.push_back(int'(inst_pc));
         done_prev = done;
         if (inst_valid && inst_ready) begin
            acc_q.push_back(int'(inst_pc));
            if (inst !== (32'(inst_pc) + 32'h100)) inst_bad++;
            if (jump_pc >= 0 && !jumped && int'(inst_pc) == jump_pc) begin
               jump_valid = 1; jump_addr = AW'(jump_tgt);
               jumped = 1; jump_cyc = cyc;
            end
         end
      end
      jump_valid = 0;
   endtask

   task automatic test_reset();
      rstn = 0; start = 0; start_addr = '0; end_addr = '0;
      jump_valid = 0; jump_addr = '0; inst_ready = 0;
      #12;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_imem_addr got %0d want 0", imem_addr); end
      n_checks++; if (inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %0h want 0", inst); end
      n_checks++; if (inst_pc !== 8'd0) begin n_fail++; $display("FAIL reset_inst_pc got %0d want 0", inst_pc); end
      @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_streaming();
      run_prog(0, 15, 0, -1, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL stream_timeout got timeout want done"); end
      n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL stream_latency got %0d want 2", first_valid); end
      n_checks++; if (acc_q.size() !== 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", acc_q.size()); end
      for (int i = 0; i < acc_q.size() && i < 16; i++) begin
         n_checks++; if (acc_q[i] !== i) begin n_fail++; $display("FAIL stream_pc[%0d] got %0d want %0d", i, acc_q[i], i); end
      end
      n_checks++; if (inst_bad !== 0) begin n_fail++; $display("FAIL stream_inst_data got %0d bad want 0", inst_bad); end
      // Back-to-back: first accept at cycle 2, last at cycle 17, no gaps
      n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL stream_stalls got %0d want 0", stall_cnt); end
      n_checks++; if (done_pcs.size() !== 1 || done_pcs[0] !== 15) begin n_fail++; $display("FAIL stream_done got %0d pulses want 1 at pc 15", done_pcs.size()); end
      n_checks++; if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL stream_busy_after_done got %b want 0", busy_after_done); end
   endtask

   task automatic test_back_pressure();
      run_prog(0, 15, 1, -1, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
      n_checks++; if (acc_q.size() !== 16) begin n_fail++; $display("FAIL bp_count got %0d want 16", acc_q.size()); end
      for (int i = 0; i < acc_q.size() && i < 16; i++) begin
         n_checks++; if (acc_q[i] !== i) begin n_fail++; $display("FAIL bp_pc[%0d] got %0d want %0d", i, acc_q[i], i); end
      end
      n_checks++; if (inst_bad !== 0) begin n_fail++; $display("FAIL bp_inst_data got %0d bad want 0", inst_bad); end
      n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable want 0", hold_bad); end
      n_checks++; if (ahead_bad !== 0) begin n_fail++; $display("FAIL bp_ahead got %0d cycles >2 ahead want 0", ahead_bad); end
      n_checks++; if (stall_cnt < 1) begin n_fail++; $display("FAIL bp_stall_seen got %0d want >0", stall_cnt); end
      n_checks++; if (done_pcs.size() !== 1 || done_pcs[0] !== 15) begin n_fail++; $display("FAIL bp_done got %0d pulses want 1 at pc 15", done_pcs.size()); end
      n_checks++; if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after_done got %b want 0", busy_after_done); end
`ifdef IFETCH_PERF_CNT_EN
      n_checks++; if (perf_fetched !== 32'd16) begin n_fail++; $display("FAIL perf_fetched got %0d want 16", perf_fetched); end
      n_checks++; if (perf_stall !== 32'(stall_cnt)) begin n_fail++; $display("FAIL perf_stall got %0d want %0d", perf_stall, stall_cnt); end
`endif
   endtask

   task automatic test_jump();
      int exp_q[$];
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      for (int i = 10; i < 16; i++) exp_q.push_back(i);
      run_prog(0, 15, 0, 3, 10);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL jump_timeout got timeout want done"); end
      n_checks++; if (acc_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL jump_count got %0d want %0d", acc_q.size(), exp_q.size()); end
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
         n_checks++; if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL jump_pc[%0d] got %0d want %0d", i, acc_q[i], exp_q[i]); end
      end
      n_checks++; if (post_jump_valid !== 0) begin n_fail++; $display("FAIL jump_flush_valid got %0d want 0", post_jump_valid); end
      n_checks++; if (inst_bad !== 0) begin n_fail++; $display("FAIL jump_inst_data got %0d bad want 0", inst_bad); end
      n_checks++; if (done_pcs.size() !== 1 || done_pcs[0] !== 15) begin n_fail++; $display("FAIL jump_done got %0d pulses want 1 at pc 15", done_pcs.size()); end
   endtask

   task automatic test_wrap();
      int exp_q[$];
      exp_q.push_back(254); exp_q.push_back(255); exp_q.push_back(0); exp_q.push_back(1);
      run_prog(254, 1, 0, -1, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL wrap_timeout got timeout want done"); end
      n_checks++; if (acc_q.size() !== 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", acc_q.size()); end
      for (int i = 0; i < acc_q.size() && i < 4; i++) begin
         n_checks++; if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %0d want %0d", i, acc_q[i], exp_q[i]); end
      end
      n_checks++; if (inst_bad !== 0) begin n_fail++; $display("FAIL wrap_inst_data got %0d bad want 0", inst_bad); end
      n_checks++; if (done_pcs.size() !== 1 || done_pcs[0] !== 1) begin n_fail++; $display("FAIL wrap_done got %0d pulses want 1 at pc 1", done_pcs.size()); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1; start_addr = 8'd0; end_addr = 8'd15; inst_ready = 0;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_stalled_valid got %b want 1", inst_valid); end
      #2 rstn = 0;
      #1;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_inst_valid got %b want 0", inst_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL rmid_imem_addr got %0d want 0", imem_addr); end
      @(negedge clk);
      rstn = 1;
      run_prog(5, 7, 0, -1, 0);
      n_checks++; if (acc_q.size() !== 3) begin n_fail++; $display("FAIL rmid_count got %0d want 3", acc_q.size()); end
      n_checks++; if (acc_q.size() < 1 || acc_q[0] !== 5) begin n_fail++; $display("FAIL rmid_first_pc got %0d want 5", (acc_q.size() > 0) ? acc_q[0] : -1); end
      n_checks++; if (done_pcs.size() !== 1 || done_pcs[0] !== 7) begin n_fail++; $display("FAIL rmid_done got %0d pulses want 1 at pc 7", done_pcs.size()); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) + 32'h100;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_jump();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the InstructionMemory for the core.
- Owns the program counter and drives the memory address each cycle.
- Absorbs the 1-cycle registered read latency and delivers instructions to the decoder over a valid/ready handshake.
- Handles start, jumps (with flush), stop-at-end-address and decoder back-pressure via a 2-entry instruction buffer.

Parameters:
ADDR_W, `INSTMEM_ADDR_WIDTH, instruction memory address width
INST_W, `INST_LENGTH, instruction word width
BUF_DEPTH, 2, instruction buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin fetching at start_addr (ignored unless IDLE)
start_addr  in  ADDR_W  first fetch address
end_addr  in  ADDR_W  last address to fetch (inclusive); sampled with start
jump_valid  in  1  redirect request
jump_addr  in  ADDR_W  redirect target
imem_addr  out  ADDR_W  address to InstructionMemory
imem_q  in  INST_W  InstructionMemory data (valid 1 cycle after address)
inst  out  INST_W  instruction to decoder
inst_pc  out  ADDR_W  address of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decoder accepts when valid&ready
busy  out  1  state != IDLE
done  out  1  1-cycle pulse when the last instruction is accepted

Behaviour:
- Reset (rstn low, async): state=IDLE, pc=0, imem_addr=0, buffer empty, pending=0, inst_valid=0, inst=0, inst_pc=0, busy=0, done=0, end register=0. A reset mid-fetch discards all in-flight and buffered data.
- States:
  - IDLE -> FETCH on start: pc<=start_addr, end<=end_addr.
  - FETCH -> DRAIN when address end is issued without a jump in the same cycle.
  - DRAIN -> IDLE when the buffer is empty, pending=0, and the last accept occurs (done pulses that cycle).
  - A jump in FETCH or DRAIN returns to FETCH.
- imem_addr = pc (registered). An issue in cycle t means imem_q carries mem[pc] in cycle t+1; pending=1 in t+1 tracks this, and the data is written into the buffer in t+1 along with its address.
- Issue rule (FETCH only): issue when count + pending - pop < 2, where pop = inst_valid&inst_ready. On issue, pc<=pc+1 modulo 2^ADDR_W (max address wraps to 0, no error). With no issue, pc holds.
- Buffer: 2-entry FIFO of {inst, pc}. inst/inst_pc/inst_valid come from the head, registered-equivalent; no combinational path from imem_q to inst.
- Throughput: 1 instruction/cycle when inst_ready is held high. First inst_valid appears 2 cycles after start (issue at t+1, buffer write at t+2).
- Back-pressure: while inst_valid & !inst_ready, inst and inst_pc are held stable. The buffer never overflows.
- Jump (jump_valid in FETCH/DRAIN):
  - Flushes the buffer and the pending read; inst_valid=0 next cycle.
  - pc<=jump_addr; the first issue occurs the following cycle.
  - Jump has priority over a simultaneous accept: the accept still completes, and done is suppressed.
  - jump_valid in IDLE is ignored.
- start while busy: ignored.
- end_addr < start_addr: fetching proceeds through wrap-around until end is issued.
- done pulses exactly once per program, in the cycle the instruction at pc==end is accepted.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32b, count of accepted instructions) and perf_stall (32b, cycles with inst_valid & !inst_ready).
  - Both counters clear on reset and on start, and saturate at all-ones.
- Undefined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared constants (constants.v):
  - INSTMEM_ADDR_WIDTH, INST_LENGTH, CLK_PERIOD (existing).
  - New IFETCH_ST_IDLE=2'd0, IFETCH_ST_FETCH=2'd1, IFETCH_ST_DRAIN=2'd2.
- One sub-module: ifetch_buf, a 2-entry synchronous FIFO with flush, count output, and registered head outputs.
- The FSM, PC and issue logic stay in inst_fetch_ctrl.

Test Plan:
- Streaming: mem[i]=i+0x100, 16 locations, start_addr=0, end_addr=15, inst_ready=1.
  - Expect first inst_valid 2 cycles after start, then 16 consecutive beats inst_pc=0..15 with inst=0x100..0x10F.
  - Expect done in the beat with pc=15, and busy low the next cycle.
- Back-pressure: same program, inst_ready toggles 1,0,0,1 repeating.
  - Expect no lost or duplicated instruction, inst held stable while stalled, and imem_addr never more than 2 ahead of the accepted pc.
- Jump: jump_valid with jump_addr=10 asserted when inst_pc=3 is accepted.
  - Expect the next accepted pc sequence 10,11,...,15.
  - Expect pcs 4/5 never presented, and done at pc=15.
- Wrap: start_addr=2^ADDR_W-2, end_addr=1.
  - Expect accepted pcs max-1, max, 0, 1, then done.
- Reset mid-operation: rstn asserted low asynchronously during a stalled transfer (inst_ready=0).
  - Expect inst_valid=0 and busy=0 immediately.
  - After release, a new start at addr 5 yields pc=5 first.
- IFETCH_PERF_CNT_EN: rerun the back-pressure test.
  - Expect perf_fetched=16, and perf_stall equal to the bench-counted stalled cycles.
